// File: rtl/cur_mb_if.sv
// cur_mb_if - pixel-stream and macroblock-memory write bundle for cur_mb_loader.
//
// Signals:
//   pix_valid/pix_data/pix_first/pix_ready : raster luma stream, one sample per handshake
//   mem_we/mem_waddr/mem_wdata             : write port of the current-macroblock memory
//   mb_full/mb_release                     : buffer-ownership handshake with the search engine
//   sync_err                               : one-cycle pulse on a mid-macroblock pix_first
//
// Modports:
//   master : the stream source / consumer side (drives samples and releases)
//   slave  : the loader itself
`timescale 1ns/1ps
interface cur_mb_if #(
  parameter int PIX_W  = 8,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_first;
  logic              pix_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mb_full;
  logic              mb_release;
  logic              sync_err;

  modport master (
    output pix_valid, pix_data, pix_first, mb_release,
    input  pix_ready, mem_we, mem_waddr, mem_wdata, mb_full, sync_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_first, mb_release,
    output pix_ready, mem_we, mem_waddr, mem_wdata, mb_full, sync_err
  );
endinterface

// File: rtl/cur_mb_loader.sv
// cur_mb_loader - packs a raster luma stream into 64-bit words and fills the
// current-macroblock memory of the motion estimator, one 16x16 block at a time.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : cur_mb_if.slave
//          pix_valid/pix_data/pix_first in, pix_ready out  - sample stream
//          mem_we/mem_waddr/mem_wdata out                  - memory write port
//          mb_full out, mb_release in                      - buffer ownership
//          sync_err out                                    - resync pulse
//
// Every output is a register, so an asynchronous reset clears all of them
// immediately, and pix_ready is low while reset is held.
`timescale 1ns/1ps
module cur_mb_loader #(
  parameter int PIX_W        = 8,
  parameter int DATA_W       = 64,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 5,
  parameter int MB_WORDS     = 32
) (
  input  logic     clk,
  input  logic     rst,
  cur_mb_if.slave  bus
);

  localparam int                BIDX_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [BIDX_W-1:0] LAST_LANE = BIDX_W'(PIX_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MB_WORDS - 1);

  generate
    if (DATA_W != PIX_W * PIX_PER_WORD) begin : g_bad_data_w
      $error("cur_mb_loader: DATA_W must equal PIX_W*PIX_PER_WORD");
    end
    if (MB_WORDS > (2 ** ADDR_W)) begin : g_bad_mb_words
      $error("cur_mb_loader: MB_WORDS must fit in ADDR_W address bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    WAIT_FIRST,
    FILL,
    DRAIN,
    FULL
  } state_t;

  state_t              state_reg,     state_next;
  logic [BIDX_W-1:0]   byte_idx_reg,  byte_idx_next;
  logic [ADDR_W-1:0]   word_idx_reg,  word_idx_next;
  logic [DATA_W-1:0]   pack_reg,      pack_next;
  logic                pix_ready_reg, pix_ready_next;
  logic                mem_we_reg,    mem_we_next;
  logic [ADDR_W-1:0]   mem_waddr_reg, mem_waddr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                mb_full_reg,   mb_full_next;
  logic                sync_err_reg,  sync_err_next;

  logic                accept;
  logic [DATA_W-1:0]   merged_word;   // pack_reg with the incoming sample dropped into its lane

  assign accept = bus.pix_valid && pix_ready_reg;

  // Lane 0 occupies the least-significant bits (little-endian packing).
  generate
    for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
      assign merged_word[gi*PIX_W +: PIX_W] =
        (byte_idx_reg == BIDX_W'(gi)) ? bus.pix_data : pack_reg[gi*PIX_W +: PIX_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= WAIT_FIRST;
      byte_idx_reg  <= '0;
      word_idx_reg  <= '0;
      pack_reg      <= '0;
      pix_ready_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= '0;
      mb_full_reg   <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_idx_reg  <= byte_idx_next;
      word_idx_reg  <= word_idx_next;
      pack_reg      <= pack_next;
      pix_ready_reg <= pix_ready_next;
      mem_we_reg    <= mem_we_next;
      mem_waddr_reg <= mem_waddr_next;
      mem_wdata_reg <= mem_wdata_next;
      mb_full_reg   <= mb_full_next;
      sync_err_reg  <= sync_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_idx_next  = byte_idx_reg;
    word_idx_next  = word_idx_reg;
    pack_next      = pack_reg;
    mem_we_next    = 1'b0;
    mem_waddr_next = mem_waddr_reg;
    mem_wdata_next = mem_wdata_reg;   // write data holds between pulses
    sync_err_next  = 1'b0;

    unique case (state_reg)
      WAIT_FIRST: begin
        // Anything before the first pix_first is discarded.
        if (accept && bus.pix_first) begin
          pack_next[PIX_W-1:0] = bus.pix_data;
          byte_idx_next        = BIDX_W'(1);
          word_idx_next        = '0;
          state_next           = FILL;
        end
      end

      FILL: begin
        if (accept) begin
          if (bus.pix_first) begin
            // FILL is always entered with byte index 1, so any pix_first here
            // is mid-block: drop what has been gathered and restart at word 0.
            pack_next[PIX_W-1:0] = bus.pix_data;
            byte_idx_next        = BIDX_W'(1);
            word_idx_next        = '0;
            sync_err_next        = 1'b1;
          end else if (byte_idx_reg == LAST_LANE) begin
            mem_we_next    = 1'b1;
            mem_waddr_next = word_idx_reg;
            mem_wdata_next = merged_word;
            pack_next      = merged_word;
            byte_idx_next  = '0;
            if (word_idx_reg == LAST_WORD) begin
              // Word index parks on the last address until the block is released.
              state_next = DRAIN;
            end else begin
              word_idx_next = word_idx_reg + ADDR_W'(1);
            end
          end else begin
            pack_next     = merged_word;
            byte_idx_next = byte_idx_reg + BIDX_W'(1);
          end
        end
      end

      DRAIN: begin
        // One cycle so the final write lands before mb_full is seen.
        state_next = FULL;
      end

      FULL: begin
        if (bus.mb_release) begin
          word_idx_next = '0;
          byte_idx_next = '0;
          state_next    = WAIT_FIRST;
        end
      end

      default: state_next = WAIT_FIRST;
    endcase

    pix_ready_next = (state_next == WAIT_FIRST) || (state_next == FILL);
    mb_full_next   = (state_next == FULL);
  end

  assign bus.pix_ready = pix_ready_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_waddr = mem_waddr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.mb_full   = mb_full_reg;
  assign bus.sync_err  = sync_err_reg;

endmodule

// File: tb/tb_cur_mb_loader.sv
// tb_cur_mb_loader - scoreboard bench for cur_mb_loader.
// Expected memory writes are queued as each stream is set up and popped by a
// monitor on every mem_we pulse; control/timing behaviour is checked inline.
`timescale 1ns/1ps
module tb_cur_mb_loader;

  localparam int PIX_W        = 8;
  localparam int DATA_W       = 64;
  localparam int PIX_PER_WORD = 8;
  localparam int ADDR_W       = 5;
  localparam int MB_WORDS     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cur_mb_if #(.PIX_W(PIX_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cur_mb_loader #(
    .PIX_W(PIX_W), .DATA_W(DATA_W), .PIX_PER_WORD(PIX_PER_WORD),
    .ADDR_W(ADDR_W), .MB_WORDS(MB_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int sync_cnt = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.sync_err === 1'b1) sync_cnt <= sync_cnt + 1;
    if (bus.mem_we === 1'b1) begin
      logic [ADDR_W+DATA_W-1:0] e;
      wr_cnt <= wr_cnt + 1;
      $display("write addr=%0d data=0x%016h", bus.mem_waddr, bus.mem_wdata);
      check("pending_write", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("waddr", 64'(bus.mem_waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("wdata", bus.mem_wdata, e[DATA_W-1:0]);
      end
    end
  end

  task automatic push_word(input int addr, input int base);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < PIX_PER_WORD; j++) w[j*PIX_W +: PIX_W] = 8'(base + j);
    exp_q.push_back({ADDR_W'(addr), w});
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input logic [7:0] d, input logic first);
    logic acc;
    int   n;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_first = first;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.pix_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    bus.pix_valid = 1'b0;
    bus.pix_first = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bus.pix_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full 256-sample macroblock, values (base+i) mod 256, pix_first on sample 0.
  task automatic fill(input int base, input bit gaps);
    for (int k = 0; k < MB_WORDS; k++) push_word(k, base + 8 * k);
    for (int i = 0; i < MB_WORDS * PIX_PER_WORD; i++) begin
      bus.mb_release = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
      send(8'(base + i), i == 0);
    end
    bus.mb_release = 1'b0;
    check("ready_after_last", 64'(bus.pix_ready), 64'd0);
    check("we_after_last", 64'(bus.mem_we), 64'd1);
    check("full_too_early", 64'(bus.mb_full), 64'd0);
    @(posedge clk);
    #1;
    check("mb_full_latency", 64'(bus.mb_full), 64'd1);
    check("we_single_pulse", 64'(bus.mem_we), 64'd0);
  endtask

  task automatic release_mb();
    bus.mb_release = 1'b1;
    @(posedge clk);
    #1;
    bus.mb_release = 1'b0;
    check("full_after_release", 64'(bus.mb_full), 64'd0);
    check("ready_after_release", 64'(bus.pix_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int bad;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.pix_first  = 1'b0;
    bus.mb_release = 1'b0;

    #2;
    check("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_waddr", 64'(bus.mem_waddr), 64'd0);
    check("rst_wdata", bus.mem_wdata, 64'd0);
    check("rst_mb_full", 64'(bus.mb_full), 64'd0);
    check("rst_sync_err", 64'(bus.sync_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(bus.pix_ready), 64'd1);

    // Continuous stream 0..255.
    wr0 = wr_cnt;
    fill(0, 1'b0);
    check("writes_continuous", 64'(wr_cnt - wr0), 64'd32);
    release_mb();

    // Same stream with random gaps and mb_release noise during FILL.
    wr0 = wr_cnt;
    fill(0, 1'b1);
    check("writes_gapped", 64'(wr_cnt - wr0), 64'd32);
    release_mb();

    // Leading samples without pix_first are dropped.
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    wr0 = wr_cnt;
    fill(8'h40, 1'b0);
    check("writes_after_drop", 64'(wr_cnt - wr0), 64'd32);
    release_mb();

    // Resync: pix_first reasserted at sample 100.
    check("sync_none_yet", 64'(sync_cnt), 64'd0);
    for (int k = 0; k < 12; k++) push_word(k, 8 * k);
    for (int i = 0; i < 100; i++) send(8'(i), i == 0);
    fill(100, 1'b0);
    check("sync_err_pulses", 64'(sync_cnt), 64'd1);
    check("queue_after_resync", 64'(exp_q.size()), 64'd0);

    // Held full with a valid source: nothing is taken.
    wr0 = wr_cnt;
    bad = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = 8'h55;
    bus.pix_first = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.pix_ready !== 1'b0) bad++;
    end
    check("ready_while_full", 64'(bad), 64'd0);
    check("writes_while_full", 64'(wr_cnt - wr0), 64'd0);
    check("full_held", 64'(bus.mb_full), 64'd1);
    bus.pix_valid = 1'b0;
    bus.pix_first = 1'b0;
    release_mb();

    // Asynchronous reset part-way through a fill.
    wr0 = wr_cnt;
    for (int k = 0; k < 5; k++) push_word(k, 8 * k);
    for (int i = 0; i < 40; i++) send(8'(i), i == 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_pix_ready", 64'(bus.pix_ready), 64'd0);
    check("async_mem_we", 64'(bus.mem_we), 64'd0);
    check("async_waddr", 64'(bus.mem_waddr), 64'd0);
    check("async_wdata", bus.mem_wdata, 64'd0);
    check("writes_before_rst", 64'(wr_cnt - wr0), 64'd5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    wr0 = wr_cnt;
    fill(8'h80, 1'b0);
    check("writes_after_rst", 64'(wr_cnt - wr0), 64'd32);
    release_mb();

    idle(3);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
